// File: rtl/block_a_mc.sv
// block_a_mc: NUM_CH tagged-input lane FIFOs drained round-robin into one registered
// valid/ready output. Define BLOCK_A_MC_DROP_CNT_EN to add the saturating drop_cnt output.
module block_a_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 4,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_vld,
    input  logic [CH_W-1:0]       data_in_ch,
    output logic                  data_in_rdy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CH_W-1:0]       data_out_ch,
    output logic                  data_en,
    input  logic                  data_out_rdy,
    output logic [NUM_CH-1:0]     lane_ne,
    output logic [NUM_CH-1:0]     lane_full,
`ifdef BLOCK_A_MC_DROP_CNT_EN
    output logic                  ch_err,
    output logic [15:0]           drop_cnt
`else
    output logic                  ch_err
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(NUM_CH);

    logic [DATA_WIDTH-1:0] mem [NUM_CH][DEPTH];
    logic [PW-1:0]         wr_ptr [NUM_CH];
    logic [PW-1:0]         rd_ptr [NUM_CH];
    logic [PW-1:0]         wr_nxt [NUM_CH];
    logic [PW-1:0]         rd_nxt [NUM_CH];
    logic [NUM_CH-1:0]     ne_nxt;
    logic [NUM_CH-1:0]     full_nxt;
    logic [NUM_CH-1:0]     push_lane;
    logic [NUM_CH-1:0]     pop_lane;
    logic [CH_W-1:0]       last_grant;
    logic [CH_W-1:0]       grant;
    logic [DATA_WIDTH-1:0] head;
    logic                  grant_vld;
    logic                  ch_legal;
    logic                  full_sel;
    logic                  slot_free;
    logic                  pop;

    // Input side: illegal tags are always accepted so the producer never stalls on them
    always_comb begin
        ch_legal = ({1'b0, data_in_ch} < CH_LIMIT);
        full_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (data_in_ch == CH_W'(i)) full_sel = lane_full[i];
        data_in_rdy = clk_en & (ch_legal ? ~full_sel : 1'b1);
        push_lane = '0;
        for (int i = 0; i < NUM_CH; i++)
            push_lane[i] = data_in_vld & data_in_rdy & (data_in_ch == CH_W'(i));
    end

    // Round-robin: lanes above last_grant first, then wrap to the low lanes
    always_comb begin
        slot_free = ~data_en | data_out_rdy;
        grant_vld = 1'b0;
        grant     = '0;
        head      = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (!grant_vld && lane_ne[i] && (i > int'(last_grant))) begin
                grant_vld = 1'b1;
                grant     = CH_W'(i);
                head      = mem[i][rd_ptr[i][AW-1:0]];
            end
        for (int i = 0; i < NUM_CH; i++)
            if (!grant_vld && lane_ne[i] && (i <= int'(last_grant))) begin
                grant_vld = 1'b1;
                grant     = CH_W'(i);
                head      = mem[i][rd_ptr[i][AW-1:0]];
            end
        pop = clk_en & slot_free & grant_vld;
        pop_lane = '0;
        for (int i = 0; i < NUM_CH; i++)
            pop_lane[i] = pop & (grant == CH_W'(i));
    end

    // Flags come from next occupancy so push+pop on one lane leaves them consistent
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_nxt[i]   = wr_ptr[i] + PW'(push_lane[i]);
            rd_nxt[i]   = rd_ptr[i] + PW'(pop_lane[i]);
            ne_nxt[i]   = (wr_nxt[i] != rd_nxt[i]);
            full_nxt[i] = (wr_nxt[i][AW-1:0] == rd_nxt[i][AW-1:0]) &&
                          (wr_nxt[i][AW] != rd_nxt[i][AW]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (push_lane[i]) mem[i][wr_ptr[i][AW-1:0]] <= data_in;
    end

    // Stage boundary: lane state and the registered output slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            lane_ne     <= '0;
            lane_full   <= '0;
            ch_err      <= 1'b0;
            last_grant  <= CH_W'(NUM_CH - 1);
            data_out    <= '0;
            data_out_ch <= '0;
            data_en     <= 1'b0;
        end else if (clk_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= wr_nxt[i];
                rd_ptr[i] <= rd_nxt[i];
            end
            lane_ne   <= ne_nxt;
            lane_full <= full_nxt;
            if (data_in_vld && !ch_legal) ch_err <= 1'b1;
            if (slot_free) begin
                if (grant_vld) begin
                    data_out    <= head;
                    data_out_ch <= grant;
                    data_en     <= 1'b1;
                    last_grant  <= grant;
                end else begin
                    data_en <= 1'b0;
                end
            end
        end
    end

`ifdef BLOCK_A_MC_DROP_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_cnt <= '0;
        else if (clk_en && data_in_vld && ch_legal && full_sel)
            drop_cnt <= sat_inc16(drop_cnt);
    end
`endif

endmodule

// File: tb/tb_block_a_mc.sv
// Directed bench for block_a_mc: a 4-lane instance for ordering/arbitration/backpressure
// and a 3-lane instance for the illegal-channel path.
module tb_block_a_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en_a, vld_a, ordy_a, irdy_a, den_a, err_a;
    logic [7:0] din_a, dout_a;
    logic [1:0] ch_a, doch_a;
    logic [3:0] ne_a, full_a;
    logic       en_b, vld_b, ordy_b, irdy_b, den_b, err_b;
    logic [7:0] din_b, dout_b;
    logic [1:0] ch_b, doch_b;
    logic [2:0] ne_b, full_b;
`ifdef BLOCK_A_MC_DROP_CNT_EN
    logic [15:0] drop_a, drop_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rr_d [5] = '{8'h21, 8'h31, 8'h02, 8'h22, 8'h32};
    logic [1:0] rr_c [5] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd3};

    block_a_mc #(.DATA_WIDTH(8), .NUM_CH(4), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .clk_en(en_a),
        .data_in(din_a), .data_in_vld(vld_a), .data_in_ch(ch_a), .data_in_rdy(irdy_a),
        .data_out(dout_a), .data_out_ch(doch_a), .data_en(den_a), .data_out_rdy(ordy_a),
        .lane_ne(ne_a), .lane_full(full_a), .ch_err(err_a)
`ifdef BLOCK_A_MC_DROP_CNT_EN
        , .drop_cnt(drop_a)
`endif
    );

    block_a_mc #(.DATA_WIDTH(8), .NUM_CH(3), .DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .clk_en(en_b),
        .data_in(din_b), .data_in_vld(vld_b), .data_in_ch(ch_b), .data_in_rdy(irdy_b),
        .data_out(dout_b), .data_out_ch(doch_b), .data_en(den_b), .data_out_rdy(ordy_b),
        .lane_ne(ne_b), .lane_full(full_b), .ch_err(err_b)
`ifdef BLOCK_A_MC_DROP_CNT_EN
        , .drop_cnt(drop_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d, input logic [1:0] c);
        din_a = d; ch_a = c; vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b1; vld_a = 1'b0; din_a = '0; ch_a = '0; ordy_a = 1'b0;
        en_b = 1'b1; vld_b = 1'b0; din_b = '0; ch_b = '0; ordy_b = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_eq("rst_den", den_a, 0);
        check_eq("rst_ne", ne_a, 0);
        check_eq("rst_err_b", err_b, 0);
        tick();
        rst = 1'b1;

        // reset in the middle of traffic
        push_a(8'h11, 2'd1);
        push_a(8'h12, 2'd1);
        check_eq("pre_rst_dout", dout_a, 8'h11);
        check_eq("pre_rst_ne", ne_a, 4'b0010);
        rst = 1'b0;
        #1;
        check_eq("async_rst_den", den_a, 0);
        check_eq("async_rst_dout", dout_a, 0);
        check_eq("async_rst_ne", ne_a, 0);
        check_eq("async_rst_full", full_a, 0);
        rst = 1'b1;
        tick();
        check_eq("post_rst_ne", ne_a, 0);
        push_a(8'h5A, 2'd0);
        check_eq("lat_edge1_den", den_a, 0);
        tick();
        check_eq("lat_edge2_den", den_a, 1);
        check_eq("lat_edge2_dout", dout_a, 8'h5A);
        check_eq("lat_edge2_ch", doch_a, 0);

        // latency and in-lane order
        ordy_a = 1'b1;
        tick();
        check_eq("idle_den", den_a, 0);
        push_a(8'hA1, 2'd0);
        check_eq("a1_not_yet", den_a, 0);
        push_a(8'hA2, 2'd0);
        check_eq("a1_dout", dout_a, 8'hA1);
        check_eq("a1_ch", doch_a, 0);
        tick();
        check_eq("a2_dout", dout_a, 8'hA2);
        check_eq("a2_den", den_a, 1);
        tick();
        check_eq("drain_den", den_a, 0);
        check_eq("drain_hold", dout_a, 8'hA2);

        // round-robin across lanes 0, 2, 3
        ordy_a = 1'b0;
        push_a(8'h01, 2'd0);
        push_a(8'h02, 2'd0);
        push_a(8'h21, 2'd2);
        push_a(8'h22, 2'd2);
        push_a(8'h31, 2'd3);
        push_a(8'h32, 2'd3);
        check_eq("rr_held_dout", dout_a, 8'h01);
        check_eq("rr_held_ch", doch_a, 0);
        check_eq("rr_held_den", den_a, 1);
        check_eq("rr_ne", ne_a, 4'b1101);
        ordy_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("rr_dout", dout_a, rr_d[k]);
            check_eq("rr_ch", doch_a, rr_c[k]);
        end
        tick();
        check_eq("rr_end_den", den_a, 0);
        check_eq("rr_end_ne", ne_a, 0);

        // full lane under backpressure
        ordy_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            din_a = 8'hB1 + 8'(k); ch_a = 2'd1; vld_a = 1'b1;
            #1;
            check_eq("fill_rdy", irdy_a, 1);
            tick();
        end
        din_a = 8'hB6;
        #1;
        check_eq("full_rdy", irdy_a, 0);
        check_eq("full_flag", full_a[1], 1);
        check_eq("bp_dout", dout_a, 8'hB1);
        ch_a = 2'd0;
        #1;
        check_eq("other_lane_rdy", irdy_a, 1);
        ch_a = 2'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("bp_hold_dout", dout_a, 8'hB1);
            check_eq("bp_hold_den", den_a, 1);
            check_eq("bp_hold_full", full_a[1], 1);
`ifdef BLOCK_A_MC_DROP_CNT_EN
            check_eq("drop_cnt", drop_a, 32'(k + 1));
`endif
        end
        vld_a = 1'b0;

        // clock-enable freeze
        ordy_a = 1'b1;
        tick();
        check_eq("pop_b2", dout_a, 8'hB2);
        check_eq("unfull", full_a[1], 0);
        en_a = 1'b0; din_a = 8'hEE; ch_a = 2'd0; vld_a = 1'b1;
        #1;
        check_eq("gated_rdy", irdy_a, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("gated_dout", dout_a, 8'hB2);
            check_eq("gated_den", den_a, 1);
            check_eq("gated_ne", ne_a, 4'b0010);
        end
`ifdef BLOCK_A_MC_DROP_CNT_EN
        check_eq("gated_drop", drop_a, 3);
`endif
        en_a = 1'b1; vld_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("resume_dout", dout_a, 8'hB3 + 8'(k));
        end
        tick();
        check_eq("resume_end_den", den_a, 0);
        check_eq("resume_end_ne", ne_a, 0);

        // illegal channel on the 3-lane instance
        din_b = 8'h77; ch_b = 2'd3; vld_b = 1'b1;
        #1;
        check_eq("illegal_rdy", irdy_b, 1);
        tick();
        vld_b = 1'b0;
        check_eq("illegal_err", err_b, 1);
        check_eq("illegal_ne", ne_b, 0);
        tick();
        check_eq("err_sticky", err_b, 1);
        check_eq("illegal_no_out", den_b, 0);
        din_b = 8'h42; ch_b = 2'd2; vld_b = 1'b1;
        tick();
        vld_b = 1'b0;
        check_eq("lane2_ne", ne_b, 3'b100);
        tick();
        check_eq("lane2_den", den_b, 1);
        check_eq("lane2_dout", dout_b, 8'h42);
        check_eq("lane2_ch", doch_b, 2);
`ifdef BLOCK_A_MC_DROP_CNT_EN
        check_eq("illegal_not_dropped", drop_b, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
